// File: rtl/power_event_accumulator.sv
// Weighted 0->1 event accumulator: per-channel power totals per fixed window, drained over valid/ready.
// Optional build macro PWR_SAT_EN: saturating accumulation with sticky per-channel sat flags.
module power_event_accumulator #(
   parameter int NSIG   = 8,
   parameter int NCH    = 4,
   parameter int CW     = 2,
   parameter int WW     = 4,
   parameter int AW     = 16,
   parameter int WINDOW = 256
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_en,
   input  logic [NSIG-1:0]    i_sig,
   input  logic [NSIG*CW-1:0] i_sig_ch,
   input  logic [NSIG*WW-1:0] i_sig_w,
   output logic               o_out_valid,
   input  logic               i_out_ready,
   output logic [CW-1:0]      o_out_ch,
   output logic [AW-1:0]      o_out_total,
   output logic               o_out_last,
   output logic [NCH-1:0]     o_sat,
   output logic               o_overrun
);

   localparam int IW  = WW + $clog2(NSIG);
   localparam int WCW = $clog2(WINDOW);

   typedef enum logic {S_IDLE, S_RUN} ctl_t;
   typedef enum logic {S_EMPTY, S_SEND} drn_t;

   ctl_t             r_ctl;
   drn_t             r_drn;
   logic [NSIG-1:0]  r_sig_q;
   logic [AW-1:0]    r_acc  [NCH];
   logic [AW-1:0]    r_snap [NCH];
   logic [WCW-1:0]   r_wcnt;
   logic [CW-1:0]    r_rd_ptr;
   logic [NCH-1:0]   r_sat;
   logic             r_overrun;
   logic             r_out_valid;
   logic [CW-1:0]    r_out_ch;
   logic [AW-1:0]    r_out_total;
   logic             r_out_last;

   logic [NSIG-1:0]  w_rise;
   logic [AW-1:0]    w_upd [NCH];
   logic [NCH-1:0]   w_ovf;
   logic             w_hs;
   logic             w_last_hs;
   logic             w_drain_idle;
   logic             w_win_end;
   logic             w_load;
   logic [CW-1:0]    w_nxt_ptr;

   assign w_rise = i_sig & ~r_sig_q;

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         logic [IW-1:0] w_inc;

         always_comb begin
            w_inc = '0;
            for (int i = 0; i < NSIG; i++) begin
               if (w_rise[i] && (i_sig_ch[i*CW +: CW] == CW'(gi)))
                  w_inc = w_inc + IW'(i_sig_w[i*WW +: WW]);
            end
         end

`ifdef PWR_SAT_EN
         logic [AW:0] w_sum;
         assign w_sum       = {1'b0, r_acc[gi]} + (AW+1)'(w_inc);
         assign w_upd[gi]   = w_sum[AW] ? {AW{1'b1}} : w_sum[AW-1:0];
         assign w_ovf[gi]   = w_sum[AW];
`else
         assign w_upd[gi]   = r_acc[gi] + AW'(w_inc);
         assign w_ovf[gi]   = 1'b0;
`endif
      end
   endgenerate

   // A final handshake on the window-end edge frees the drain for the new snapshot.
   assign w_hs         = r_out_valid & i_out_ready;
   assign w_last_hs    = w_hs & (r_rd_ptr == CW'(NCH-1));
   assign w_drain_idle = (r_drn == S_EMPTY) | w_last_hs;
   assign w_win_end    = (r_ctl == S_RUN) & (r_wcnt == WCW'(WINDOW-1));
   assign w_load       = w_win_end & w_drain_idle;
   assign w_nxt_ptr    = r_rd_ptr + 1'b1;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_ctl     <= S_IDLE;
         r_sig_q   <= '0;
         r_wcnt    <= '0;
         r_sat     <= '0;
         r_overrun <= 1'b0;
         for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
      end else begin
         r_sig_q <= i_sig;
         case (r_ctl)
            S_IDLE: begin
               if (i_en) r_ctl <= S_RUN;
            end
            S_RUN: begin
               if (i_en || w_win_end) r_sat <= r_sat | w_ovf;
               if (w_win_end && !w_drain_idle) r_overrun <= 1'b1;
               if (!i_en || w_win_end) begin
                  r_wcnt <= '0;
                  for (int c = 0; c < NCH; c++) r_acc[c] <= '0;
               end else begin
                  r_wcnt <= r_wcnt + 1'b1;
                  for (int c = 0; c < NCH; c++) r_acc[c] <= w_upd[c];
               end
               if (!i_en) r_ctl <= S_IDLE;
            end
            default: r_ctl <= S_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_drn       <= S_EMPTY;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b0;
         r_out_ch    <= '0;
         r_out_total <= '0;
         r_out_last  <= 1'b0;
         for (int c = 0; c < NCH; c++) r_snap[c] <= '0;
      end else if (w_load) begin
         for (int c = 0; c < NCH; c++) r_snap[c] <= w_upd[c];
         r_drn       <= S_SEND;
         r_rd_ptr    <= '0;
         r_out_valid <= 1'b1;
         r_out_ch    <= '0;
         r_out_total <= w_upd[0];
         r_out_last  <= (NCH == 1);
      end else if (w_hs) begin
         if (w_last_hs) begin
            r_drn       <= S_EMPTY;
            r_rd_ptr    <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
         end else begin
            r_rd_ptr    <= w_nxt_ptr;
            r_out_ch    <= w_nxt_ptr;
            r_out_total <= r_snap[w_nxt_ptr];
            r_out_last  <= (w_nxt_ptr == CW'(NCH-1));
         end
      end
   end

   assign o_out_valid = r_out_valid;
   assign o_out_ch    = r_out_ch;
   assign o_out_total = r_out_total;
   assign o_out_last  = r_out_last;
   assign o_sat       = r_sat;
   assign o_overrun   = r_overrun;

endmodule
